// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller:
// FSM state encoding, EX/MEM M-field bit positions and the default timeout.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam int M_BRANCH = 2;
    localparam int M_READ   = 1;
    localparam int M_WRITE  = 0;

    localparam int DEFAULT_TIMEOUT = 15;

    // Branch bit does not touch memory; only MemRead/MemWrite start an access.
    function automatic logic is_mem_access(input logic [2:0] m);
        return m[M_READ] | m[M_WRITE];
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Memory-side request/ack bus between the access controller (master)
// and the data memory (slave).
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// WAIT-state watchdog: down-counter loaded with LIMIT-1 while idle,
// decremented while enabled; tc flags the LIMIT-th enabled cycle.
// Only built when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] LOAD = 8'(LIMIT - 1);

    logic [7:0] cnt_q;

    // Reload on clear, count down toward zero while the access is waiting.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 8'd0;
        else if (clear)
            cnt_q <= LOAD;
        else if (enable && (cnt_q != 8'd0))
            cnt_q <= cnt_q - 8'd1;
    end

    assign tc = enable && (cnt_q == 8'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller: turns EX/MEM load/store requests
// into a held req/ack transaction and stalls the front of the pipeline
// until it completes.
// Optional: define MEM_ACCESS_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without ack (err pulse, rdata_out cleared).
//
// state | meaning
// IDLE  | no access pending; a load/store stalls this cycle and is latched
// WAIT  | request held on the bus until ack (or timeout)
// DONE  | pipeline released; rdata_valid / err pulse for one cycle
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        m_ctrl,
    input  logic [31:0]       alu_addr,
    input  logic [31:0]       wdata_in,
    mem_access_ctrl_if.master mem,
    output logic              stall,
    output logic [31:0]       rdata_out,
    output logic              rdata_valid,
    output logic              err
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

    mem_state_t  state_q, state_d;
    logic        latch, capture, timeout_hit, tc;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state, stall and datapath strobes; ack only matters in WAIT.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        latch       = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_access(m_ctrl)) begin
                    stall   = 1'b1;
                    latch   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (mem.ack) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (tc) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (rst)
            stall = 1'b0;
    end

    // Request fields latched on entry to WAIT; load data captured on ack.
    // Write wins when MemRead and MemWrite are both set.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (latch) begin
                we_q    <= m_ctrl[M_WRITE];
                addr_q  <= alu_addr;
                wdata_q <= wdata_in;
            end
            if (capture && !we_q)
                rdata_q <= mem.rdata;
            else if (timeout_hit)
                rdata_q <= 32'd0;
        end
    end

    assign mem.req   = (state_q == ST_WAIT);
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign rdata_out = rdata_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic to_q;

    mem_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_WAIT),
        .enable (state_q == ST_WAIT),
        .tc     (tc)
    );

    // Remembers that the access now in DONE ended by timeout.
    always_ff @(posedge clk) begin
        if (rst)
            to_q <= 1'b0;
        else
            to_q <= timeout_hit;
    end

    assign err         = (state_q == ST_DONE) && to_q;
    assign rdata_valid = (state_q == ST_DONE) && !we_q && !to_q;
`else
    assign tc          = 1'b0;
    assign err         = 1'b0;
    assign rdata_valid = (state_q == ST_DONE) && !we_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  m_ctrl = 3'b000;
    logic [31:0] alu_addr = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        stall, rdata_valid, err;
    logic [31:0] rdata_out;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_ctrl      (m_ctrl),
        .alu_addr    (alu_addr),
        .wdata_in    (wdata_in),
        .mem         (bus),
        .stall       (stall),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input logic ak, input logic [31:0] rd);
        @(negedge clk);
        rst       = r;
        m_ctrl    = m;
        alu_addr  = a;
        wdata_in  = wd;
        bus.ack   = ak;
        bus.rdata = rd;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 3'b010, 32'h40, 32'h1, 1'b0, 32'd0);
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        step(1'b1, 3'b011, 32'h44, 32'h2, 1'b1, 32'hFFFF_FFFF);
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall2: got %b want 0", stall); end
        n_cmp++; if ({bus.req, bus.we, rdata_valid, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {bus.req, bus.we, rdata_valid, err}); end
        n_cmp++; if ({bus.addr, bus.wdata, rdata_out} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {bus.addr, bus.wdata, rdata_out}); end
    endtask

    task automatic test_load();
        int sc = 0, rc = 0, vc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i <= 3) ? 3'b010 : 3'b000, 32'h0000_0040, 32'd0,
                 (i == 3), (i == 3) ? 32'hDEAD_BEEF : 32'd0);
            if (stall) sc++;
            if (bus.req) rc++;
            if (rdata_valid) vc++;
            if (i == 0) begin
                n_cmp++; if ({stall, bus.req} !== 2'b10) begin n_fail++; $display("FAIL load_req_cycle: got %b want 10", {stall, bus.req}); end
            end
            if (i == 1) begin
                n_cmp++; if ({bus.req, bus.we} !== 2'b10) begin n_fail++; $display("FAIL load_wait_ctl: got %b want 10", {bus.req, bus.we}); end
                n_cmp++; if (bus.addr !== 32'h40) begin n_fail++; $display("FAIL load_addr: got %h want 00000040", bus.addr); end
            end
            if (i == 4) begin
                n_cmp++; if (rdata_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", rdata_out); end
                n_cmp++; if ({rdata_valid, stall, bus.req} !== 3'b100) begin n_fail++; $display("FAIL load_done: got %b want 100", {rdata_valid, stall, bus.req}); end
            end
        end
        n_cmp++; if (sc !== 4) begin n_fail++; $display("FAIL load_stall_cycles: got %0d want 4", sc); end
        n_cmp++; if (rc !== 3) begin n_fail++; $display("FAIL load_req_cycles: got %0d want 3", rc); end
        n_cmp++; if (vc !== 1) begin n_fail++; $display("FAIL load_valid_pulses: got %0d want 1", vc); end
    endtask

    task automatic test_store(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd);
        int sc = 0, vc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, (i <= 1) ? m : 3'b000, a, wd, (i == 1), 32'h0BAD_0BAD);
            if (stall) sc++;
            if (rdata_valid) vc++;
            if (i == 1) begin
                n_cmp++; if ({bus.req, bus.we} !== 2'b11) begin n_fail++; $display("FAIL store_ctl m=%b: got %b want 11", m, {bus.req, bus.we}); end
                n_cmp++; if ({bus.addr, bus.wdata} !== {a, wd}) begin n_fail++; $display("FAIL store_bus m=%b: got %h want %h", m, {bus.addr, bus.wdata}, {a, wd}); end
            end
            if (i == 2) begin
                n_cmp++; if (rdata_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_rdata_kept: got %h want deadbeef", rdata_out); end
            end
        end
        n_cmp++; if (sc !== 2) begin n_fail++; $display("FAIL store_stall_cycles m=%b: got %0d want 2", m, sc); end
        n_cmp++; if (vc !== 0) begin n_fail++; $display("FAIL store_no_valid m=%b: got %0d want 0", m, vc); end
    endtask

    task automatic test_ack_outside_wait();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 3'b000, 32'h99, 32'h99, (i == 0), 32'hFFFF_FFFF);
            n_cmp++; if ({stall, bus.req, rdata_valid, err} !== 4'b0000) begin n_fail++; $display("FAIL stray_ack_ctl: got %b want 0000", {stall, bus.req, rdata_valid, err}); end
            n_cmp++; if (rdata_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stray_ack_rdata: got %h want deadbeef", rdata_out); end
        end
    endtask

    task automatic test_timeout();
        int rc = 0, ec = 0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i <= 4) ? 3'b010 : 3'b000, 32'h80, 32'd0, (i == 6), 32'h5555_5555);
            if (bus.req) rc++;
            if (err) ec++;
            if (i == 5) begin
                n_cmp++; if ({bus.req, err, rdata_valid, stall} !== 4'b0100) begin n_fail++; $display("FAIL timeout_done: got %b want 0100", {bus.req, err, rdata_valid, stall}); end
                n_cmp++; if (rdata_out !== 32'd0) begin n_fail++; $display("FAIL timeout_rdata: got %h want 0", rdata_out); end
            end
            if (i == 7) begin
                n_cmp++; if (rdata_out !== 32'd0) begin n_fail++; $display("FAIL timeout_late_ack: got %h want 0", rdata_out); end
            end
        end
        n_cmp++; if (rc !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 4", rc); end
        n_cmp++; if (ec !== 1) begin n_fail++; $display("FAIL timeout_err_pulses: got %0d want 1", ec); end
        // ack in the same cycle the count expires: completion wins
        ec = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, (i <= 4) ? 3'b010 : 3'b000, 32'h84, 32'd0, (i == 4), 32'h0BAD_CAFE);
            if (err) ec++;
            if (i == 5) begin
                n_cmp++; if ({rdata_valid, rdata_out} !== {1'b1, 32'h0BAD_CAFE}) begin n_fail++; $display("FAIL ack_wins: got %b/%h want 1/0badcafe", rdata_valid, rdata_out); end
            end
        end
        n_cmp++; if (ec !== 0) begin n_fail++; $display("FAIL ack_wins_err: got %0d want 0", ec); end
`else
        for (int i = 0; i < 11; i++) begin
            step(1'b0, (i <= 8) ? 3'b010 : 3'b000, 32'h84, 32'd0, (i == 8), 32'h0BAD_CAFE);
            if (bus.req) rc++;
            if (err) ec++;
            if (i == 9) begin
                n_cmp++; if ({rdata_valid, rdata_out} !== {1'b1, 32'h0BAD_CAFE}) begin n_fail++; $display("FAIL long_wait_done: got %b/%h want 1/0badcafe", rdata_valid, rdata_out); end
            end
        end
        n_cmp++; if (rc !== 8) begin n_fail++; $display("FAIL long_wait_req_cycles: got %0d want 8", rc); end
        n_cmp++; if (ec !== 0) begin n_fail++; $display("FAIL long_wait_err: got %0d want 0", ec); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        step(1'b0, 3'b011, 32'h200, 32'hAAAA_AAAA, 1'b0, 32'd0);
        step(1'b0, 3'b011, 32'h200, 32'hAAAA_AAAA, 1'b0, 32'd0);
        n_cmp++; if ({bus.req, bus.we, bus.addr} !== {2'b11, 32'h200}) begin n_fail++; $display("FAIL rst_wait_pre: got %b%b/%h want 11/00000200", bus.req, bus.we, bus.addr); end
        step(1'b1, 3'b011, 32'h200, 32'hAAAA_AAAA, 1'b0, 32'd0);
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_wait_stall: got %b want 0", stall); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 3'b000, 32'd0, 32'd0, (i == 0), 32'h7777_7777);
            n_cmp++; if ({stall, bus.req, bus.we, rdata_valid, err} !== 5'b00000) begin n_fail++; $display("FAIL rst_wait_ctl%0d: got %b want 00000", i, {stall, bus.req, bus.we, rdata_valid, err}); end
            n_cmp++; if ({bus.addr, bus.wdata, rdata_out} !== 96'd0) begin n_fail++; $display("FAIL rst_wait_data%0d: got %h want 0", i, {bus.addr, bus.wdata, rdata_out}); end
        end
    endtask

    task automatic test_mixed_stream();
        logic [2:0]  mv     [9] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000};
        logic [31:0] av     [9] = '{32'h0, 32'h10, 32'h10, 32'h10, 32'h14, 32'h14, 32'h14, 32'h0, 32'h0};
        logic        ackv   [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
        logic [31:0] rdv    [9] = '{32'h0, 32'h0, 32'hA1, 32'h0, 32'h0, 32'hB2, 32'h0, 32'h0, 32'h0};
        logic        e_stl  [9] = '{0, 1, 1, 0, 1, 1, 0, 0, 0};
        logic        e_req  [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
        logic        e_val  [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            step(1'b0, mv[i], av[i], 32'd0, ackv[i], rdv[i]);
            n_cmp++; if ({stall, bus.req, rdata_valid} !== {e_stl[i], e_req[i], e_val[i]}) begin n_fail++; $display("FAIL mixed_c%0d: got stall/req/valid %b want %b", i, {stall, bus.req, rdata_valid}, {e_stl[i], e_req[i], e_val[i]}); end
            if (e_req[i]) begin
                n_cmp++; if ({bus.we, bus.addr} !== {1'b0, av[i]}) begin n_fail++; $display("FAIL mixed_bus_c%0d: got %b/%h want 0/%h", i, bus.we, bus.addr, av[i]); end
            end
        end
        n_cmp++; if (rdata_out !== 32'hB2) begin n_fail++; $display("FAIL mixed_last_rdata: got %h want 000000b2", rdata_out); end
    endtask

    initial begin
        bus.ack   = 1'b0;
        bus.rdata = 32'd0;
        test_reset();
        test_load();
        test_store(3'b001, 32'h0000_0100, 32'h1234_5678);
        test_store(3'b011, 32'h0000_0300, 32'hCAFE_F00D);
        test_ack_outside_wait();
        test_timeout();
        test_reset_mid_wait();
        test_mixed_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
